fp_matmul_seq: RTL

Parametrised, resource-shared IEEE-754 single-precision matrix multiplier computing C = A·B, or C = A·B + C_in in accumulate mode, for DIM×DIM square matrices. It uses one `single_multiplier` and one `adder` instance, sequenced by an internal FSM over (i, j, k), so area stays flat as DIM grows. It sits in the matrix datapath with the same operand/result handshake as the fixed 2×2 multiplier and replaces it where DIM > 2 or accumulation is needed.

---
 rtl/fp_matmul_seq.sv | 328 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/fp_matmul_seq.sv
// Resource-shared single-precision matrix multiplier: C = A*B (+ C_in), DIMxDIM,
// one multiplier and one adder sequenced over (i, j, k).

module single_multiplier (
   input  logic        input_Clk,
   input  logic        input_Reset,
   input  logic [31:0] input_a,
   input  logic        input_a_stb,
   output logic        input_a_ack,
   input  logic [31:0] input_b,
   input  logic        input_b_stb,
   output logic        input_b_ack,
   output logic [31:0] output_z,
   output logic        output_z_stb,
   input  logic        output_z_ack
);
   localparam logic [31:0] QNAN = 32'h7FC00000;

   logic [31:0] a_q, b_q, z_q;
   logic        got_a_q, got_b_q, a_ack_q, b_ack_q, z_stb_q;

   // Round-to-nearest-even; subnormal inputs and results flush to zero.
   function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
      logic              s, g, st;
      logic [47:0]       p;
      logic [24:0]       m;
      logic signed [9:0] e;
      logic [31:0]       r;
      s = a[31] ^ b[31];
      p = '0; m = '0; g = 1'b0; st = 1'b0; e = '0; r = '0;
      if ((a[30:23] == 8'hFF && a[22:0] != '0) || (b[30:23] == 8'hFF && b[22:0] != '0))
         r = QNAN;
      else if (a[30:23] == 8'hFF || b[30:23] == 8'hFF)
         r = (a[30:23] == 8'h00 || b[30:23] == 8'h00) ? QNAN : {s, 8'hFF, 23'd0};
      else if (a[30:23] == 8'h00 || b[30:23] == 8'h00)
         r = {s, 31'd0};
      else begin
         p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
         e = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
         if (p[47]) begin
            m = {1'b0, p[47:24]}; g = p[23]; st = |p[22:0]; e = e + 10'sd1;
         end else begin
            m = {1'b0, p[46:23]}; g = p[22]; st = |p[21:0];
         end
         if (g && (st || m[0])) m = m + 25'd1;
         if (m[24]) begin m = m >> 1; e = e + 10'sd1; end
         if (e >= 10'sd255)    r = {s, 8'hFF, 23'd0};
         else if (e <= 10'sd0) r = {s, 31'd0};
         else                  r = {s, e[7:0], m[22:0]};
      end
      return r;
   endfunction

   always_ff @(posedge input_Clk or negedge input_Reset) begin
      if (!input_Reset) begin
         a_q <= '0; b_q <= '0; z_q <= '0;
         got_a_q <= 1'b0; got_b_q <= 1'b0;
         a_ack_q <= 1'b0; b_ack_q <= 1'b0; z_stb_q <= 1'b0;
      end else begin
         a_ack_q <= 1'b0;
         b_ack_q <= 1'b0;
         if (input_a_stb && !got_a_q && !z_stb_q) begin
            a_q <= input_a; got_a_q <= 1'b1; a_ack_q <= 1'b1;
         end
         if (input_b_stb && !got_b_q && !z_stb_q) begin
            b_q <= input_b; got_b_q <= 1'b1; b_ack_q <= 1'b1;
         end
         if (got_a_q && got_b_q && !z_stb_q) begin
            z_q <= fp_mul(a_q, b_q); z_stb_q <= 1'b1;
            got_a_q <= 1'b0; got_b_q <= 1'b0;
         end else if (z_stb_q && output_z_ack) begin
            z_stb_q <= 1'b0;
         end
      end
   end

   assign input_a_ack  = a_ack_q;
   assign input_b_ack  = b_ack_q;
   assign output_z     = z_q;
   assign output_z_stb = z_stb_q;
endmodule

module adder (
   input  logic        input_Clk,
   input  logic        input_Reset,
   input  logic [31:0] Number1,
   input  logic [31:0] Number2,
   input  logic        load,
   output logic [31:0] Result,
   output logic        result_ready,
   input  logic        result_ack
);
   localparam logic [31:0] QNAN = 32'h7FC00000;

   logic [31:0] n1_q, n2_q, res_q;
   logic        pend_q, ready_q;

   function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
      logic [31:0]       x, y, r;
      logic [27:0]       mx, my, sum;
      logic [7:0]        d;
      logic signed [9:0] e;
      logic [24:0]       m;
      logic              g, st, sticky;
      x = a; y = b; r = '0; mx = '0; my = '0; sum = '0; d = '0; e = '0; m = '0;
      g = 1'b0; st = 1'b0; sticky = 1'b0;
      if ((a[30:23] == 8'hFF && a[22:0] != '0) || (b[30:23] == 8'hFF && b[22:0] != '0))
         r = QNAN;
      else if (a[30:23] == 8'hFF)
         r = (b[30:23] == 8'hFF && a[31] != b[31]) ? QNAN : a;
      else if (b[30:23] == 8'hFF)
         r = b;
      else if (a[30:23] == 8'h00)
         r = (b[30:23] == 8'h00) ? {a[31] & b[31], 31'd0} : b;
      else if (b[30:23] == 8'h00)
         r = a;
      else begin
         if (b[30:0] > a[30:0]) begin x = b; y = a; end
         d  = x[30:23] - y[30:23];
         mx = {2'b01, x[22:0], 3'b000};
         my = {2'b01, y[22:0], 3'b000};
         // Bits shifted out of the smaller operand collapse into a sticky bit.
         sticky = |(my & ((28'd1 << d) - 28'd1));
         my     = my >> d;
         my[0]  = my[0] | sticky;
         e   = $signed({2'b00, x[30:23]});
         sum = (x[31] == y[31]) ? mx + my : mx - my;
         if (sum == '0)
            r = '0;
         else begin
            if (sum[27]) begin
               sum = {1'b0, sum[27:2], sum[1] | sum[0]}; e = e + 10'sd1;
            end
            for (int n = 0; n < 26; n++)
               if (!sum[26]) begin sum = sum << 1; e = e - 10'sd1; end
            m  = {1'b0, sum[26:3]};
            g  = sum[2];
            st = |sum[1:0];
            if (g && (st || m[0])) m = m + 25'd1;
            if (m[24]) begin m = m >> 1; e = e + 10'sd1; end
            if (e >= 10'sd255)    r = {x[31], 8'hFF, 23'd0};
            else if (e <= 10'sd0) r = {x[31], 31'd0};
            else                  r = {x[31], e[7:0], m[22:0]};
         end
      end
      return r;
   endfunction

   always_ff @(posedge input_Clk or negedge input_Reset) begin
      if (!input_Reset) begin
         n1_q <= '0; n2_q <= '0; res_q <= '0; pend_q <= 1'b0; ready_q <= 1'b0;
      end else begin
         if (load) begin
            n1_q <= Number1; n2_q <= Number2; pend_q <= 1'b1;
         end
         if (pend_q) begin
            res_q <= fp_add(n1_q, n2_q); ready_q <= 1'b1; pend_q <= 1'b0;
         end else if (ready_q && result_ack) begin
            ready_q <= 1'b0;
         end
      end
   end

   assign Result       = res_q;
   assign result_ready = ready_q;
endmodule

// state | meaning
// IDLE  | waiting for operands
// MUL   | product A[i][k]*B[k][j] in flight
// ADD   | acc + product in flight
// STORE | acc written to result buffer at (i,j), indices advance
// DONE  | result presented, waiting for consumer ack
module fp_matmul_seq #(
   parameter int DIM = 2
) (
   input  logic                  input_Clk,
   input  logic                  input_Reset,
   input  logic                  input_Stable,
   input  logic                  input_Accumulate,
   input  logic [DIM*DIM*32-1:0] input_A,
   input  logic [DIM*DIM*32-1:0] input_B,
   input  logic [DIM*DIM*32-1:0] input_C,
   output logic                  output_AB_Ack,
   output logic                  output_Busy,
   output logic [DIM*DIM*32-1:0] output_C,
   output logic                  output_Stable,
   input  logic                  input_C_Ack
);
   localparam int         W    = DIM*DIM*32;
   localparam logic [3:0] LAST = 4'(DIM-1);

   typedef enum logic [2:0] {S_IDLE, S_MUL, S_ADD, S_STORE, S_DONE} state_t;

   state_t      state_q;
   logic [W-1:0] a_q, b_q, c_q, res_q, out_c_q, res_wr;
   logic        accum_q, ab_ack_q, busy_q, stable_q;
   logic [3:0]  i_q, j_q, k_q;
   logic [31:0] acc_q, prod_q, op_a, op_b, c_el;
   logic        mul_a_stb_q, mul_b_stb_q, mul_z_ack_q, add_load_q, add_ack_q;
   logic        mul_a_ack, mul_b_ack, mul_z_stb, add_ready;
   logic [31:0] mul_z, add_res;

   function automatic int el(input logic [3:0] r, input logic [3:0] c);
      return (int'(r) * DIM + int'(c)) * 32;
   endfunction

   assign op_a = a_q[el(i_q, k_q) +: 32];
   assign op_b = b_q[el(k_q, j_q) +: 32];
   assign c_el = c_q[el(i_q, j_q) +: 32];

   always_comb begin
      res_wr = res_q;
      res_wr[el(i_q, j_q) +: 32] = acc_q;
   end

   single_multiplier u_mul (
      .input_Clk   (input_Clk),
      .input_Reset (input_Reset),
      .input_a     (op_a),
      .input_a_stb (mul_a_stb_q),
      .input_a_ack (mul_a_ack),
      .input_b     (op_b),
      .input_b_stb (mul_b_stb_q),
      .input_b_ack (mul_b_ack),
      .output_z    (mul_z),
      .output_z_stb(mul_z_stb),
      .output_z_ack(mul_z_ack_q)
   );

   adder u_add (
      .input_Clk   (input_Clk),
      .input_Reset (input_Reset),
      .Number1     (acc_q),
      .Number2     (prod_q),
      .load        (add_load_q),
      .Result      (add_res),
      .result_ready(add_ready),
      .result_ack  (add_ack_q)
   );

   always_ff @(posedge input_Clk or negedge input_Reset) begin
      if (!input_Reset) begin
         state_q <= S_IDLE;
         a_q <= '0; b_q <= '0; c_q <= '0; res_q <= '0; out_c_q <= '0;
         accum_q <= 1'b0; ab_ack_q <= 1'b0; busy_q <= 1'b0; stable_q <= 1'b0;
         i_q <= '0; j_q <= '0; k_q <= '0; acc_q <= '0; prod_q <= '0;
         mul_a_stb_q <= 1'b0; mul_b_stb_q <= 1'b0; mul_z_ack_q <= 1'b0;
         add_load_q <= 1'b0; add_ack_q <= 1'b0;
      end else begin
         mul_z_ack_q <= 1'b0;
         add_load_q  <= 1'b0;
         if (ab_ack_q && !input_Stable) ab_ack_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (input_Stable && !ab_ack_q) begin
                  a_q <= input_A; b_q <= input_B; c_q <= input_C;
                  accum_q <= input_Accumulate;
                  i_q <= '0; j_q <= '0; k_q <= '0;
                  ab_ack_q <= 1'b1; busy_q <= 1'b1;
                  mul_a_stb_q <= 1'b1; mul_b_stb_q <= 1'b1;
                  state_q <= S_MUL;
               end
            end
            S_MUL: begin
               if (mul_a_ack) mul_a_stb_q <= 1'b0;
               if (mul_b_ack) mul_b_stb_q <= 1'b0;
               if (!mul_a_stb_q && !mul_b_stb_q && mul_z_stb && !mul_z_ack_q) begin
                  mul_z_ack_q <= 1'b1;
                  prod_q      <= mul_z;
                  if (k_q == 4'd0) acc_q <= accum_q ? c_el : mul_z;
                  // First term without accumulate seeds acc directly, no adder pass.
                  if (k_q == 4'd0 && !accum_q) begin
                     if (k_q == LAST) state_q <= S_STORE;
                     else begin
                        k_q <= k_q + 4'd1;
                        mul_a_stb_q <= 1'b1; mul_b_stb_q <= 1'b1;
                     end
                  end else begin
                     add_load_q <= 1'b1;
                     state_q    <= S_ADD;
                  end
               end
            end
            S_ADD: begin
               if (add_ready && !add_ack_q) begin
                  acc_q <= add_res; add_ack_q <= 1'b1;
               end else if (add_ack_q && !add_ready) begin
                  add_ack_q <= 1'b0;
                  if (k_q == LAST) state_q <= S_STORE;
                  else begin
                     k_q <= k_q + 4'd1;
                     mul_a_stb_q <= 1'b1; mul_b_stb_q <= 1'b1;
                     state_q <= S_MUL;
                  end
               end
            end
            S_STORE: begin
               res_q <= res_wr;
               k_q   <= '0;
               if (i_q == LAST && j_q == LAST) begin
                  out_c_q  <= res_wr;
                  stable_q <= 1'b1;
                  state_q  <= S_DONE;
               end else begin
                  if (j_q == LAST) begin j_q <= '0; i_q <= i_q + 4'd1; end
                  else j_q <= j_q + 4'd1;
                  mul_a_stb_q <= 1'b1; mul_b_stb_q <= 1'b1;
                  state_q <= S_MUL;
               end
            end
            S_DONE: begin
               if (input_C_Ack) begin
                  stable_q <= 1'b0; busy_q <= 1'b0;
                  i_q <= '0; j_q <= '0;
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign output_AB_Ack = ab_ack_q;
   assign output_Busy   = busy_q;
   assign output_C      = out_c_q;
   assign output_Stable = stable_q;
endmodule
